pbkdf2_iter_ctrl: RTL
=====================

Name: pbkdf2_iter_ctrl

Overview:
- Iteration sequencer for PBKDF2-HMAC-SHA3-256 key derivation (one output block, T1).
- Drives a shared HMAC core through a start/valid handshake. Feeds it salt||INT(1) first, then each previous digest U(i-1).
- XOR-accumulates U1..Uc into the derived key and raises o_ready when done.
- Sits between the top-level key-derivation wrapper and the HMAC-SHA3 datapath.

Parameters:
- ITER_W, 16, width of the iteration-count input.
- KEY_W, 256, digest / derived-key width.
- MSG_W, 1088, HMAC message block width (SHA3-256 rate).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- i_start  input  1  job request; sampled only in IDLE or DONE
- i_pw  input  MSG_W  password, used as the HMAC key
- i_salt  input  MSG_W-32  salt
- i_iter  input  ITER_W  iteration count c; 0 treated as 1
- o_hmac_start  output  1  one-cycle HMAC launch pulse
- o_hmac_key  output  MSG_W  HMAC key, equal to the latched password
- o_hmac_msg  output  MSG_W  HMAC message block
- o_hmac_len  output  11  valid message bits (1088 or 256)
- i_hmac_valid  input  1  HMAC digest valid pulse
- i_hmac_digest  input  KEY_W  HMAC digest
- o_key  output  KEY_W  derived key T1
- o_ready  output  1  key valid; level
- o_busy  output  1  job in progress
- o_iter_left  output  ITER_W  remaining iterations

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE.
- Reset (synchronous, active-high): state=IDLE; all outputs 0; internal pw/salt/acc/U registers 0. Applies mid-job: the job is abandoned and any later i_hmac_valid is ignored.
- IDLE or DONE with i_start=1:
  - latch i_pw and i_salt;
  - cnt = (i_iter==0) ? 1 : i_iter;
  - first=1; acc=0;
  - o_ready=0; next state ISSUE.
- i_start in ISSUE or WAIT is ignored.
- ISSUE (exactly 1 cycle):
  - o_hmac_start=1; next state WAIT.
  - first=1: o_hmac_msg={salt, 32'h00000001}, o_hmac_len=1088.
  - first=0: o_hmac_msg={U, (MSG_W-KEY_W)'b0}, o_hmac_len=256.
  - o_hmac_key=latched pw.
  - o_hmac_msg and o_hmac_len hold stable from ISSUE through WAIT.
- WAIT, on the edge sampling i_hmac_valid=1:
  - U=digest;
  - acc = first ? digest : acc^digest;
  - first=0; cnt=cnt-1;
  - cnt was 1: next state DONE, else ISSUE.
- i_hmac_valid outside WAIT (including the ISSUE cycle) is ignored.
- DONE: o_ready=1 and o_key=acc, held until the next accepted i_start or rst.
- o_key reads 0 whenever o_ready=0.
- o_busy=1 in ISSUE and WAIT only.
- o_iter_left=cnt; it is 0 in IDLE and DONE.
- Latency: with an HMAC core asserting valid L edges after the edge that samples o_hmac_start, o_ready rises at edge c*(L+1) after the i_start edge (cnt=c ≥ 1).
- Iteration count wraps only through the 0→1 rule; c=2^ITER_W-1 is the maximum.
- Only one HMAC job is outstanding at any time; o_hmac_start never reasserts before valid.

Test Plan:
- c=1, stub digest D=0x11..11 (256-bit), L=4 -> o_hmac_msg low 32 bits=0x00000001 and len=1088; o_ready rises at edge 5; o_key=0x11..11.
- c=3, stub returns A=0xAA..AA, B=0x0F..0F, C=0x33..33 -> 2nd issue msg={A,832'b0}, len=256; 3rd issue msg={B,832'b0}; o_key=A^B^C=0x96..96; o_iter_left steps 3,2,1,0.
- c=0 -> behaves exactly as c=1: single o_hmac_start, o_ready at edge L+1.
- i_start pulsed again during WAIT with different i_pw -> ignored; o_hmac_key unchanged; result matches the first job. i_start in DONE -> o_ready drops next cycle and a new job runs.
- rst=1 for one cycle mid-WAIT (c=5) -> next cycle all outputs 0 and state IDLE. A late i_hmac_valid causes no state change and no o_ready.
- Spurious i_hmac_valid during IDLE and in the ISSUE cycle -> acc and cnt unchanged; final o_key matches the golden value for c=2, L=2 (o_ready at edge 6).

Source files
------------

// File: rtl/pbkdf2_iter_ctrl.sv
// rtl/pbkdf2_iter_ctrl.sv - PBKDF2-HMAC-SHA3-256 iteration sequencer (single output block T1)
// Drives one outstanding HMAC job at a time and XOR-folds U1..Uc into the derived key.
module pbkdf2_iter_ctrl #(
  parameter int ITER_W = 16,
  parameter int KEY_W  = 256,
  parameter int MSG_W  = 1088
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [MSG_W-1:0]  i_pw,
  input  logic [MSG_W-33:0] i_salt,
  input  logic [ITER_W-1:0] i_iter,
  output logic              o_hmac_start,
  output logic [MSG_W-1:0]  o_hmac_key,
  output logic [MSG_W-1:0]  o_hmac_msg,
  output logic [10:0]       o_hmac_len,
  input  logic              i_hmac_valid,
  input  logic [KEY_W-1:0]  i_hmac_digest,
  output logic [KEY_W-1:0]  o_key,
  output logic              o_ready,
  output logic              o_busy,
  output logic [ITER_W-1:0] o_iter_left
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [MSG_W-1:0]    pw_q, pw_d;
  logic [MSG_W-33:0]   salt_q, salt_d;
  logic [KEY_W-1:0]    acc_q, acc_d;
  logic [KEY_W-1:0]    u_q, u_d;
  logic [ITER_W-1:0]   cnt_q, cnt_d;
  logic                first_q, first_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pw_q    <= '0;
      salt_q  <= '0;
      acc_q   <= '0;
      u_q     <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pw_q    <= pw_d;
      salt_q  <= salt_d;
      acc_q   <= acc_d;
      u_q     <= u_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pw_d    = pw_q;
    salt_d  = salt_q;
    acc_d   = acc_q;
    u_d     = u_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          pw_d    = i_pw;
          salt_d  = i_salt;
          // c=0 is folded onto c=1 so at least one HMAC call always runs
          cnt_d   = (i_iter == '0) ? ITER_W'(1) : i_iter;
          first_d = 1'b1;
          acc_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (i_hmac_valid) begin
          u_d     = i_hmac_digest;
          acc_d   = first_q ? i_hmac_digest : (acc_q ^ i_hmac_digest);
          first_d = 1'b0;
          cnt_d   = cnt_q - ITER_W'(1);
          state_d = (cnt_q == ITER_W'(1)) ? S_DONE : S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_hmac_start = (state_q == S_ISSUE);
    o_busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);
    o_ready      = (state_q == S_DONE);
    o_key        = o_ready ? acc_q : '0;
    o_iter_left  = cnt_q;
    o_hmac_key   = pw_q;
    o_hmac_msg   = '0;
    o_hmac_len   = '0;
    // Message stays stable across ISSUE and WAIT; it reads 0 when no job is running
    if (o_busy) begin
      if (first_q) begin
        o_hmac_msg = {salt_q, 32'h0000_0001};
        o_hmac_len = 11'(MSG_W);
      end else begin
        o_hmac_msg = {u_q, {(MSG_W-KEY_W){1'b0}}};
        o_hmac_len = 11'(KEY_W);
      end
    end
  end

endmodule
